// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry layout, stall encoding.
package fetch_unit_pkg;

  localparam int FETCH_PC_W    = 8;
  localparam int FETCH_INSTR_W = 32;

  // Presented to decode whenever the queue is empty (canonical NOP encoding).
  localparam logic [31:0] STALL_INSTRUCTION = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with single-cycle flush; head is combinational off the storage.
// No internal overflow guard: the producer reserves a slot before every push.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  T                         push_dat_i,
  input  logic                     pop_i,
  output T                         head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    count_q;
  logic           do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Push and pop together at full is safe: the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: one outstanding memory request, response lands in decode queue one cycle later.
// Issue waits for a reserved queue slot; FETCH_MISALIGN_TRAP_EN traps misaligned redirects instead of aligning down.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W       = FETCH_PC_W,
  parameter int              INSTR_W    = FETCH_INSTR_W,
  parameter int              FIFO_DEPTH = 4,
  parameter int              PC_STEP    = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_base,
  input  logic [PC_W-1:0]    redirect_offset,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_rsp_valid,
  input  logic [INSTR_W-1:0] mem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               fetch_fault
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            req_vld_q;
  logic            fault_q;

  logic [PC_W-1:0] target;
  logic [PC_W-1:0] target_rem;
  logic [PC_W-1:0] redir_pc;
  logic            trap;
  logic [CW-1:0]   count;
  logic            q_empty;
  entry_t          head;
  entry_t          push_dat;
  logic            push;
  logic            accept;
  logic            issue_idle;
  logic            issue_wait;

  assign target     = redirect_base + redirect_offset;
  assign target_rem = target % STEP;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap     = (target_rem != '0);
  assign redir_pc = target;
`else
  assign trap     = 1'b0;
  assign redir_pc = target - target_rem;
`endif

  assign accept = req_vld_q && mem_req_ready;
  assign push   = (state_q == WAIT) && mem_rsp_valid && !redirect;

  // Leaving WAIT the pushed response still occupies a slot, so one more entry must fit.
  assign issue_idle = !halt && !fault_q && (int'(count) + 1 <= FIFO_DEPTH);
  assign issue_wait = !halt && !fault_q && (int'(count) + 2 <= FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      req_vld_q <= 1'b0;
      fault_q   <= 1'b0;
    end else if (redirect) begin
      pc_q      <= redir_pc;
      fault_q   <= trap;
      req_vld_q <= 1'b0;
      case (state_q)
        REQ:        state_q <= accept ? DROP : IDLE;
        WAIT, DROP: state_q <= mem_rsp_valid ? IDLE : DROP;
        default:    state_q <= IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_idle) begin
            state_q   <= REQ;
            req_vld_q <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state_q   <= WAIT;
            req_vld_q <= 1'b0;
            req_pc_q  <= pc_q;
            pc_q      <= pc_q + STEP;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state_q   <= issue_wait ? REQ : IDLE;
            req_vld_q <= issue_wait;
          end
        end
        DROP: begin
          if (mem_rsp_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push_dat.instr = mem_rsp_data;
  assign push_dat.pc    = req_pc_q;

  fetch_queue #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (instr_ready),
    .head_o     (head),
    .empty_o    (q_empty),
    .count_o    (count)
  );

  assign mem_req_valid = req_vld_q;
  assign mem_addr      = pc_q;
  assign instr_valid   = !q_empty;
  assign instr         = q_empty ? INSTR_W'(STALL_INSTRUCTION) : head.instr;
  assign instr_pc      = q_empty ? '0 : head.pc;
  assign fetch_fault   = fault_q;

endmodule
